// File: rtl/program_memory_arbiter.sv
// Round-robin arbiter sharing one pipelined program-memory read port between NUM_REQ requesters.
// Latency: grant is combinational, read issued next cycle, response LATENCY cycles after issue.
// Backpressure: requesters wait for req_ready_out; the return path has none and stays in order.
//
// Ports:
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   req_valid_in/req_addr_in  per-requester read request (address slice i = [32*i+:32])
//   req_ready_out             one-hot grant, request taken on valid & ready
//   resp_valid_out            one-hot response strobe; resp_data_out / resp_err_out shared
//   mem_addr_out, mem_read_request_out, mem_instr_in, mem_data_valid_in   memory read port
//   protocol_err_out          sticky: memory valid without a tag, or a tag without memory valid
// Optional feature: define PMEM_ARB_ADDR_CHECK_EN to reject misaligned or out-of-range addresses
// with an error response instead of issuing them to the memory.
module program_memory_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int LATENCY   = 2,
  parameter int MEM_BYTES = 8192
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [NUM_REQ-1:0]      req_valid_in,
  input  logic [32*NUM_REQ-1:0]   req_addr_in,
  output logic [NUM_REQ-1:0]      req_ready_out,
  output logic [NUM_REQ-1:0]      resp_valid_out,
  output logic [31:0]             resp_data_out,
  output logic                    resp_err_out,
  output logic [31:0]             mem_addr_out,
  output logic                    mem_read_request_out,
  input  logic [31:0]             mem_instr_in,
  input  logic                    mem_data_valid_in,
  output logic                    protocol_err_out
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LATENCY + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || LATENCY < 1 || MEM_BYTES < 4) begin : g_bad_params
    $error("program_memory_arbiter: unsupported parameter values");
  end

  // Per-requester address view
  logic [31:0] addr_arr [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign addr_arr[i] = req_addr_in[32*i +: 32];
  end

  // Arbitration
  logic [IW-1:0]      ptr;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_any;
  logic [IW-1:0]      cand_idx;
  int                 cand;
  logic [31:0]        sel_addr;
  logic               acc_err;

  // Scan from ptr upward, wrapping; the first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IW'(cand);
      if (!grant_any && req_valid_in[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  assign req_ready_out = grant;
  assign sel_addr      = addr_arr[grant_idx];

  // Tag pipe: stage 0 is aligned with the issue register, the last stage with returning data.
  logic          tag_vld [0:LATENCY];
  logic [IW-1:0] tag_idx [0:LATENCY];
  logic          tag_err [0:LATENCY];
  logic          last_vld;
  logic [IW-1:0] last_idx;
  logic          last_err;

  assign last_vld = tag_vld[LATENCY];
  assign last_idx = tag_idx[LATENCY];
  assign last_err = tag_err[LATENCY];

`ifdef PMEM_ARB_ADDR_CHECK_EN
  // Rejected requests still take a tag slot so they return in order at normal latency.
  assign acc_err = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} >= 33'(MEM_BYTES));
  assign resp_err_out = last_vld & last_err;
`else
  assign acc_err      = 1'b0;
  assign resp_err_out = 1'b0;
`endif

  // Issue stage and priority pointer
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr                  <= '0;
      mem_read_request_out <= 1'b0;
      mem_addr_out         <= '0;
    end else begin
      mem_read_request_out <= grant_any & ~acc_err;
      if (grant_any && !acc_err) mem_addr_out <= sel_addr;
      if (grant_any) ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int s = 0; s <= LATENCY; s++) begin
        tag_vld[s] <= 1'b0;
        tag_idx[s] <= '0;
        tag_err[s] <= 1'b0;
      end
    end else begin
      tag_vld[0] <= grant_any;
      tag_idx[0] <= grant_idx;
      tag_err[0] <= acc_err;
      for (int s = 1; s <= LATENCY; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_idx[s] <= tag_idx[s-1];
        tag_err[s] <= tag_err[s-1];
      end
    end
  end

  // Response routing: data is zero unless a non-error tag is at the last stage.
  always_comb begin
    resp_valid_out = '0;
    if (last_vld) resp_valid_out[last_idx] = 1'b1;
  end

  assign resp_data_out = (last_vld && !last_err) ? mem_instr_in : 32'h0;

  // Protocol check. Reads issued before a reset can still return during the first LATENCY
  // cycles after release; hold_cnt masks those stale valids.
  logic [CW-1:0] hold_cnt;
  logic          in_window;
  logic          expect_data;

  assign in_window   = (hold_cnt != CW'(LATENCY));
  assign expect_data = last_vld & ~last_err;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hold_cnt         <= '0;
      protocol_err_out <= 1'b0;
    end else begin
      if (in_window) hold_cnt <= hold_cnt + CW'(1);
      if ((mem_data_valid_in && !expect_data && !in_window) ||
          (expect_data && !mem_data_valid_in))
        protocol_err_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_program_memory_arbiter.sv
module tb_program_memory_arbiter;

  localparam int N   = 3;
  localparam int LAT = 2;

  logic          clk_in;
  logic          rst_n_in;
  logic [N-1:0]  req_valid_in;
  logic [31:0]   addr_arr [N];
  logic [32*N-1:0] req_addr_in;
  logic [N-1:0]  req_ready_out;
  logic [N-1:0]  resp_valid_out;
  logic [31:0]   resp_data_out;
  logic          resp_err_out;
  logic [31:0]   mem_addr_out;
  logic          mem_read_request_out;
  logic [31:0]   mem_instr_in;
  logic          mem_data_valid_in;
  logic          protocol_err_out;

  assign req_addr_in = {addr_arr[2], addr_arr[1], addr_arr[0]};

  program_memory_arbiter #(.NUM_REQ(N), .LATENCY(LAT), .MEM_BYTES(8192)) dut (
    .clk_in               (clk_in),
    .rst_n_in             (rst_n_in),
    .req_valid_in         (req_valid_in),
    .req_addr_in          (req_addr_in),
    .req_ready_out        (req_ready_out),
    .resp_valid_out       (resp_valid_out),
    .resp_data_out        (resp_data_out),
    .resp_err_out         (resp_err_out),
    .mem_addr_out         (mem_addr_out),
    .mem_read_request_out (mem_read_request_out),
    .mem_instr_in         (mem_instr_in),
    .mem_data_valid_in    (mem_data_valid_in),
    .protocol_err_out     (protocol_err_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  function automatic logic addr_bad(input logic [31:0] a);
`ifdef PMEM_ARB_ADDR_CHECK_EN
    return (a[1:0] != 2'b00) || (a >= 32'd8192);
`else
    return (a === 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (v[2'(i)]) return i;
    end
    return -1;
  endfunction

  // Memory model: 2-cycle pipelined RAM, plus an injectable spurious valid.
  logic        spurious = 1'b0;
  logic        pa_v = 1'b0, pb_v = 1'b0, out_v;
  logic [31:0] pa_a = '0, pb_a = '0, out_a;

  initial begin
    mem_data_valid_in = 1'b0;
    mem_instr_in      = 32'h0;
    forever begin
      @(posedge clk_in);
      #2;
      out_v = pb_v;  out_a = pb_a;
      pb_v  = pa_v;  pb_a  = pa_a;
      pa_v  = mem_read_request_out;
      pa_a  = mem_addr_out;
      mem_data_valid_in = out_v | spurious;
      mem_instr_in      = out_v ? mem_word(out_a) : (spurious ? 32'h5A5A5A5A : 32'h0);
    end
  end

  // Reference model: expected events keyed by cycle number.
  logic [31:0] iss_addr [int];
  int          rsp_idx  [int];
  logic        rsp_err  [int];
  logic [31:0] rsp_addr [int];
  int          cyc      = 0;
  int          ptr_m    = 0;
  logic        perr_m   = 1'b0;
  int          last_low = -100;
  int          g_m;
  logic [N-1:0] exp_rdy, exp_rv;
  logic        exp_e, data_due, e_m;
  logic [31:0] exp_d, a_m;

  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      iss_addr.delete(); rsp_idx.delete(); rsp_err.delete(); rsp_addr.delete();
      ptr_m = 0; perr_m = 1'b0; last_low = cyc;
      g_m = rr_pick(req_valid_in, 0);
      exp_rdy = (g_m >= 0) ? N'(1 << g_m) : '0;
      chk("rst_ready", 32'(req_ready_out), 32'(exp_rdy));
      chk("rst_resp_valid", 32'(resp_valid_out), 32'h0);
      chk("rst_resp_data", resp_data_out, 32'h0);
      chk("rst_resp_err", 32'(resp_err_out), 32'h0);
      chk("rst_mem_req", 32'(mem_read_request_out), 32'h0);
      chk("rst_mem_addr", mem_addr_out, 32'h0);
      chk("rst_perr", 32'(protocol_err_out), 32'h0);
    end else begin
      g_m = rr_pick(req_valid_in, ptr_m);
      exp_rdy = (g_m >= 0) ? N'(1 << g_m) : '0;
      chk("ready", 32'(req_ready_out), 32'(exp_rdy));
      chk("mem_req", 32'(mem_read_request_out), 32'(iss_addr.exists(cyc)));
      if (iss_addr.exists(cyc)) chk("mem_addr", mem_addr_out, iss_addr[cyc]);
      if (rsp_idx.exists(cyc)) begin
        exp_rv = N'(1 << rsp_idx[cyc]);
        exp_e  = rsp_err[cyc];
        exp_d  = exp_e ? 32'h0 : mem_word(rsp_addr[cyc]);
        chk("resp_valid", 32'(resp_valid_out), 32'(exp_rv));
        chk("resp_err", 32'(resp_err_out), 32'(exp_e));
        chk("resp_data", resp_data_out, exp_d);
      end else begin
        chk("resp_idle", 32'(resp_valid_out), 32'h0);
        chk("resp_err_idle", 32'(resp_err_out), 32'h0);
      end
      chk("perr", 32'(protocol_err_out), 32'(perr_m));
      // Advance the model across the coming edge.
      data_due = rsp_idx.exists(cyc) && !rsp_err[cyc];
      if (cyc >= last_low + 1 + LAT && mem_data_valid_in && !data_due) perr_m = 1'b1;
      if (data_due && !mem_data_valid_in) perr_m = 1'b1;
      if (g_m >= 0) begin
        a_m = addr_arr[g_m];
        e_m = addr_bad(a_m);
        if (!e_m) iss_addr[cyc + 1] = a_m;
        rsp_idx[cyc + 1 + LAT]  = g_m;
        rsp_err[cyc + 1 + LAT]  = e_m;
        rsp_addr[cyc + 1 + LAT] = a_m;
        ptr_m = (g_m + 1) % N;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic int oh2idx(input logic [N-1:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  int grants [6];
  int exp_g  [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    rst_n_in     = 1'b0;
    req_valid_in = '0;
    for (int i = 0; i < N; i++) addr_arr[i] = '0;
    repeat (3) tick();
    @(negedge clk_in);
    chk("reset_mem_addr", mem_addr_out, 32'h0);
    chk("reset_perr", 32'(protocol_err_out), 32'h0);
    tick(); rst_n_in = 1'b1;
    repeat (3) tick();

    // All three requesting for six cycles from ptr=0
    for (int k = 0; k < 6; k++) begin
      tick();
      req_valid_in = 3'b111;
      for (int i = 0; i < N; i++) addr_arr[i] = 32'(32'h100 * (i + 1) + 4 * k);
      @(negedge clk_in);
      grants[k] = oh2idx(req_ready_out);
    end
    tick(); req_valid_in = '0;
    repeat (4) tick();
    for (int k = 0; k < 6; k++) chk($sformatf("rr_grant%0d", k), 32'(grants[k]), 32'(exp_g[k]));

    // Single request from requester 1
    tick(); req_valid_in = 3'b010; addr_arr[1] = 32'h10;
    @(negedge clk_in);
    chk("single_ready", 32'(req_ready_out), 32'h2);
    tick(); req_valid_in = '0;
    @(negedge clk_in);
    chk("single_mem_req", 32'(mem_read_request_out), 32'h1);
    chk("single_mem_addr", mem_addr_out, 32'h10);
    tick(); tick();
    @(negedge clk_in);
    chk("single_resp_valid", 32'(resp_valid_out), 32'h2);
    chk("single_resp_data", resp_data_out, 32'hDEADBEEF);
    repeat (2) tick();

    // Back-to-back from requester 0
    for (int k = 0; k < 3; k++) begin
      tick(); req_valid_in = 3'b001; addr_arr[0] = 32'(4 * k);
    end
    tick(); req_valid_in = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      chk($sformatf("b2b_valid%0d", k), 32'(resp_valid_out), 32'h1);
      chk($sformatf("b2b_data%0d", k), resp_data_out, 32'hC0DE0000 + 32'(4 * k));
      tick();
    end
    repeat (2) tick();

    // Reset one cycle after two grants
    tick(); req_valid_in = 3'b011; addr_arr[0] = 32'h40; addr_arr[1] = 32'h44;
    tick();
    tick(); req_valid_in = '0; rst_n_in = 1'b0;
    @(negedge clk_in);
    chk("midrst_resp_valid", 32'(resp_valid_out), 32'h0);
    chk("midrst_mem_req", 32'(mem_read_request_out), 32'h0);
    chk("midrst_mem_addr", mem_addr_out, 32'h0);
    tick(); rst_n_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      chk($sformatf("post_rst_resp%0d", k), 32'(resp_valid_out), 32'h0);
      chk($sformatf("post_rst_perr%0d", k), 32'(protocol_err_out), 32'h0);
      tick();
    end

    // Spurious memory valid with an empty pipe
    spurious = 1'b1;
    @(negedge clk_in);
    chk("spur_perr_before", 32'(protocol_err_out), 32'h0);
    tick(); spurious = 1'b0;
    @(negedge clk_in);
    chk("spur_perr_set", 32'(protocol_err_out), 32'h1);
    chk("spur_no_resp", 32'(resp_valid_out), 32'h0);
    repeat (3) tick();
    @(negedge clk_in);
    chk("spur_perr_sticky", 32'(protocol_err_out), 32'h1);

    // Requester 2: unaligned/out-of-range address, then an aligned in-range one
    tick(); req_valid_in = 3'b100; addr_arr[2] = 32'h2002;
    @(negedge clk_in);
    chk("chk_ready", 32'(req_ready_out), 32'h4);
    tick(); addr_arr[2] = 32'h1FFC;
    @(negedge clk_in);
`ifdef PMEM_ARB_ADDR_CHECK_EN
    chk("chk_bad_not_issued", 32'(mem_read_request_out), 32'h0);
`else
    chk("chk_bad_issued", 32'(mem_read_request_out), 32'h1);
`endif
    tick(); req_valid_in = '0;
    @(negedge clk_in);
    chk("chk_good_issued", 32'(mem_read_request_out), 32'h1);
    chk("chk_good_addr", mem_addr_out, 32'h1FFC);
    tick();
    @(negedge clk_in);
    chk("chk_bad_resp_valid", 32'(resp_valid_out), 32'h4);
`ifdef PMEM_ARB_ADDR_CHECK_EN
    chk("chk_bad_resp_err", 32'(resp_err_out), 32'h1);
    chk("chk_bad_resp_data", resp_data_out, 32'h0);
`else
    chk("chk_bad_resp_err", 32'(resp_err_out), 32'h0);
    chk("chk_bad_resp_data", resp_data_out, 32'hC0DE2002);
`endif
    tick();
    @(negedge clk_in);
    chk("chk_good_resp_valid", 32'(resp_valid_out), 32'h4);
    chk("chk_good_resp_err", 32'(resp_err_out), 32'h0);
    chk("chk_good_resp_data", resp_data_out, 32'hC0DE1FFC);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
